huffman_job_sequencer: RTL and testbench
========================================

Name: huffman_job_sequencer

Overview:
- Front-end controller for the Huffman `Top` core; accepts one job descriptor at a time from the host.
- For each job it:
  - programs the selected CSRs through the `csr_write` port,
  - sets the mode and issues one `io_req`,
  - counts response bytes,
  - detects completion or a hang,
  - reports a single done record back to the host.
- Sits between the host/command queue and `Top`; it owns `Top`'s `encoding`, `csr_*` and `req_*` inputs.

Parameters:
- TIMEOUT_CYCLES, 10000: busy-phase cycles without completion before the job is aborted with an error.
- CSR_W, 11: width of each CSR data field.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- job_valid  in  1  descriptor valid
- job_ready  out  1  sequencer can accept a descriptor
- job_encoding  in  1  1 = encode, 0 = decode
- job_head  in  32  request head address
- job_length  in  32  request length in bytes
- job_csr  in  4*CSR_W  CSR values; CSR n is bits [n*CSR_W +: CSR_W]
- job_csr_mask  in  4  bit n set = write CSR n for this job
- encoding  out  1  mode to `Top`
- csr_write  out  1  CSR write strobe to `Top`
- csr_addr  out  2  CSR index
- csr_data  out  CSR_W  CSR value
- req_valid  out  1  request valid to `Top`
- req_ready  in  1  `Top` idle / ready
- req_head  out  32  request head
- req_length  out  32  request length
- resp_valid  in  1  `Top` produced a byte this cycle
- done_valid  out  1  one-cycle completion pulse
- done_count  out  32  number of `resp_valid` cycles in the job
- done_error  out  1  job ended by timeout

Behaviour:
- Reset (async, any state), all registers cleared:
  - state = IDLE; job_ready = 1.
  - encoding, csr_write, csr_addr, csr_data, req_valid, req_head, req_length = 0.
  - done_valid, done_count, done_error = 0.
- IDLE:
  - job_ready = 1.
  - On job_valid & job_ready, latch all job fields, drive `encoding` from the latched mode, clear the byte counter and set the CSR index to 0.
  - Next state is CSR if mask ≠ 0, otherwise ISSUE.
- CSR:
  - One cycle per CSR index 0..3, in ascending order.
  - Masked-in index: csr_write = 1, csr_addr = index, csr_data = field.
  - Masked-out index: csr_write = 0 for that cycle (fixed 4-cycle phase, no skipping).
  - After index 3, go to ISSUE.
- ISSUE:
  - Assert req_valid with the latched head and length.
  - Hold req_valid until req_valid & req_ready is seen at a clock edge (the fire); it drops the following cycle.
  - Then go to GUARD.
- GUARD:
  - Exactly 1 cycle; req_ready is ignored here, covering `Top`'s one-cycle ready deassertion.
  - resp_valid is still counted.
  - Go to BUSY.
- BUSY:
  - Byte counter increments on each resp_valid.
  - Watchdog increments each cycle.
  - If req_ready = 1 and resp_valid = 0, go to DONE with error = 0.
  - If resp_valid = 1 in the same cycle as req_ready, count the byte and stay in BUSY one more cycle.
  - If the watchdog reaches TIMEOUT_CYCLES, go to DONE with error = 1, even if a byte is present in that cycle (that byte is still counted).
- DONE:
  - done_valid = 1 for exactly 1 cycle; done_count = counter, done_error as set.
  - done_count and done_error hold their values until the next DONE.
  - Go to IDLE.
- job_ready is 0 in every state except IDLE; descriptors are never accepted mid-job.
- `encoding` holds the latched mode from acceptance until the next accepted job, including across DONE.
- Counter widths:
  - Byte counter is 32 bits and saturates at 2^32−1.
  - Watchdog is clog2(TIMEOUT_CYCLES+1) bits and resets on job acceptance.
- job_valid in any non-IDLE state: ignored; the host must hold it.
- Reset mid-job: all outputs return to their reset values asynchronously; no done pulse is emitted for the aborted job.

Test Plan:
- Encode job, mask 4'b0111, csr = {0, 1536, 1024, 0}, head 0, len 1000; `Top` model emits 523 bytes then ready → csr_write on cycles 1..3 only, addrs 0..2 with data 0/1024/1536; one req_valid fire; done_count = 523, done_error = 0.
- Decode job, mask 4'b0001, csr0 = 256 → exactly one CSR write (addr 0, data 256); encoding = 0 from the acceptance edge; done_count = 1000.
- Mask 0 with req_ready held low for 5 cycles in ISSUE → no csr_write; req_valid stays high 5 cycles and fires on the 6th; req_ready high in GUARD is ignored.
- Model never re-asserts req_ready, TIMEOUT_CYCLES = 50 → done_valid after 50 BUSY cycles, done_error = 1, job_ready = 1 on the following cycle.
- resp_valid and req_ready high in the same BUSY cycle → byte counted, done one cycle later, count includes it.
- Assert reset during BUSY → outputs zero immediately (async), no done_valid; a new job after reset completes normally.

Source files
------------

// File: rtl/huffman_job_sequencer.sv
// Huffman job sequencer: takes one job descriptor from the host, programs
// the selected CSRs of the Huffman Top core, issues a single request, counts
// the response bytes, and reports one done record (count + timeout flag).
module huffman_job_sequencer #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int CSR_W          = 11
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic               job_encoding,
    input  logic [31:0]        job_head,
    input  logic [31:0]        job_length,
    input  logic [4*CSR_W-1:0] job_csr,
    input  logic [3:0]         job_csr_mask,
    output logic               encoding,
    output logic               csr_write,
    output logic [1:0]         csr_addr,
    output logic [CSR_W-1:0]   csr_data,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [31:0]        req_head,
    output logic [31:0]        req_length,
    input  logic               resp_valid,
    output logic               done_valid,
    output logic [31:0]        done_count,
    output logic               done_error
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        CSR,
        ISSUE,
        GUARD,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [4*CSR_W-1:0] csr_q;
    logic [3:0]         mask_q;
    logic [1:0]         csr_idx;
    logic [31:0]        byte_cnt;
    logic [31:0]        byte_cnt_next;
    logic [WD_W-1:0]    watchdog;
    logic               accept;
    logic               count_byte;
    logic               complete;
    logic               timed_out;

    // Saturating byte count including the byte (if any) seen this cycle.
    assign byte_cnt_next = (count_byte && (byte_cnt != 32'hFFFF_FFFF)) ? byte_cnt + 32'd1 : byte_cnt;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and all strobes toward Top and the host.
    always_comb begin
        state_next = state;
        job_ready  = 1'b0;
        csr_write  = 1'b0;
        csr_addr   = 2'd0;
        csr_data   = '0;
        req_valid  = 1'b0;
        done_valid = 1'b0;
        accept     = 1'b0;
        count_byte = 1'b0;
        complete   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    accept     = 1'b1;
                    state_next = (job_csr_mask != 4'd0) ? CSR : ISSUE;
                end
            end
            CSR: begin
                if (mask_q[csr_idx]) begin
                    csr_write = 1'b1;
                    csr_addr  = csr_idx;
                    csr_data  = csr_q[int'(csr_idx)*CSR_W +: CSR_W];
                end
                if (csr_idx == 2'd3) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    state_next = GUARD;
                end
            end
            GUARD: begin
                count_byte = resp_valid;
                state_next = BUSY;
            end
            BUSY: begin
                count_byte = resp_valid;
                if (req_ready && !resp_valid) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end else if (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timed_out  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Job latch, CSR index, byte counter, watchdog and the held done record.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            encoding   <= 1'b0;
            req_head   <= 32'd0;
            req_length <= 32'd0;
            csr_q      <= '0;
            mask_q     <= 4'd0;
            csr_idx    <= 2'd0;
            byte_cnt   <= 32'd0;
            watchdog   <= '0;
            done_count <= 32'd0;
            done_error <= 1'b0;
        end else begin
            if (accept) begin
                encoding   <= job_encoding;
                req_head   <= job_head;
                req_length <= job_length;
                csr_q      <= job_csr;
                mask_q     <= job_csr_mask;
                csr_idx    <= 2'd0;
                byte_cnt   <= 32'd0;
                watchdog   <= '0;
            end else begin
                byte_cnt <= byte_cnt_next;
            end
            if (state == CSR) begin
                csr_idx <= csr_idx + 2'd1;
            end
            if (state == BUSY) begin
                watchdog <= watchdog + 1'b1;
            end
            if (complete || timed_out) begin
                done_count <= byte_cnt_next;
                done_error <= timed_out;
            end
        end
    end

endmodule

// File: tb/tb_huffman_job_sequencer.sv
// Self-checking bench for huffman_job_sequencer: directed test-plan jobs plus
// randomized jobs, each checked against a cycle plan for the Top core model.
module tb_huffman_job_sequencer;

    localparam int TIMEOUT = 1100;
    localparam int CSR_W   = 11;

    logic               clock = 1'b0;
    logic               reset;
    logic               job_valid;
    logic               job_ready;
    logic               job_encoding;
    logic [31:0]        job_head;
    logic [31:0]        job_length;
    logic [4*CSR_W-1:0] job_csr;
    logic [3:0]         job_csr_mask;
    logic               encoding;
    logic               csr_write;
    logic [1:0]         csr_addr;
    logic [CSR_W-1:0]   csr_data;
    logic               req_valid;
    logic               req_ready;
    logic [31:0]        req_head;
    logic [31:0]        req_length;
    logic               resp_valid;
    logic               done_valid;
    logic [31:0]        done_count;
    logic               done_error;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    // Top core behaviour after the request fire: index 0 is the guard cycle.
    bit resp_plan[$];
    bit ready_plan[$];
    bit tail_ready;

    huffman_job_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .CSR_W(CSR_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_encoding(job_encoding),
        .job_head(job_head),
        .job_length(job_length),
        .job_csr(job_csr),
        .job_csr_mask(job_csr_mask),
        .encoding(encoding),
        .csr_write(csr_write),
        .csr_addr(csr_addr),
        .csr_data(csr_data),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_head(req_head),
        .req_length(req_length),
        .resp_valid(resp_valid),
        .done_valid(done_valid),
        .done_count(done_count),
        .done_error(done_error)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Hard stop in case the run ever overshoots its timeline.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_cnt++;
        assert (observed === expected) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            fail_cnt = fail_cnt + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_values();
        check_output("rst_job_ready",  64'(job_ready),  64'd1);
        check_output("rst_encoding",   64'(encoding),   64'd0);
        check_output("rst_csr_write",  64'(csr_write),  64'd0);
        check_output("rst_csr_addr",   64'(csr_addr),   64'd0);
        check_output("rst_csr_data",   64'(csr_data),   64'd0);
        check_output("rst_req_valid",  64'(req_valid),  64'd0);
        check_output("rst_req_head",   64'(req_head),   64'd0);
        check_output("rst_req_length", 64'(req_length), 64'd0);
        check_output("rst_done_valid", 64'(done_valid), 64'd0);
        check_output("rst_done_count", 64'(done_count), 64'd0);
        check_output("rst_done_error", 64'(done_error), 64'd0);
    endtask

    // Runs one job from IDLE; abort_at >= 1 asserts reset in that busy cycle.
    task automatic apply_stimulus(input bit enc, input logic [31:0] head, input logic [31:0] len,
                                  input logic [4*CSR_W-1:0] csr, input logic [3:0] mask,
                                  input int stall, input int abort_at);
        int done_i;
        int exp_count;
        bit exp_err;
        bit r;
        bit rd;
        exp_count = 0;
        exp_err   = 1'b0;
        done_i    = -1;
        for (int i = 0; done_i < 0; i++) begin
            r  = (i < resp_plan.size())  ? resp_plan[i]  : 1'b0;
            rd = (i < ready_plan.size()) ? ready_plan[i] : tail_ready;
            if (r) exp_count++;
            if (i > 0) begin
                if (rd && !r) begin
                    done_i = i;
                end else if (i == TIMEOUT) begin
                    done_i  = i;
                    exp_err = 1'b1;
                end
            end
        end

        check_output("idle_job_ready", 64'(job_ready), 64'd1);
        job_valid    = 1'b1;
        job_encoding = enc;
        job_head     = head;
        job_length   = len;
        job_csr      = csr;
        job_csr_mask = mask;
        req_ready    = 1'b1;
        resp_valid   = 1'b0;
        @(negedge clock);
        job_valid    = 1'b0;
        job_encoding = ~enc;
        job_head     = $urandom;
        job_length   = $urandom;
        job_csr      = 44'({$urandom, $urandom});
        job_csr_mask = 4'($urandom);
        check_output("encoding_at_accept", 64'(encoding), 64'(enc));

        if (mask != 4'd0) begin
            for (int k = 0; k < 4; k++) begin
                check_output("csr_write", 64'(csr_write), 64'(mask[k]));
                if (mask[k]) begin
                    check_output("csr_addr", 64'(csr_addr), 64'(k));
                    check_output("csr_data", 64'(csr_data), 64'(csr[k*CSR_W +: CSR_W]));
                end
                check_output("csr_req_valid", 64'(req_valid), 64'd0);
                check_output("busy_job_ready", 64'(job_ready), 64'd0);
                @(negedge clock);
            end
        end

        for (int s = 0; s <= stall; s++) begin
            req_ready = (s == stall);
            check_output("issue_req_valid", 64'(req_valid), 64'd1);
            check_output("issue_req_head", 64'(req_head), 64'(head));
            check_output("issue_req_length", 64'(req_length), 64'(len));
            check_output("issue_csr_write", 64'(csr_write), 64'd0);
            @(negedge clock);
        end

        for (int i = 0; i <= done_i; i++) begin
            resp_valid = (i < resp_plan.size())  ? resp_plan[i]  : 1'b0;
            req_ready  = (i < ready_plan.size()) ? ready_plan[i] : tail_ready;
            if (i == 0 || i == done_i) begin
                check_output("post_fire_req_valid", 64'(req_valid), 64'd0);
            end
            check_output("early_done_valid", 64'(done_valid), 64'd0);
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check_reset_values();
                @(negedge clock);
                reset      = 1'b0;
                resp_valid = 1'b0;
                req_ready  = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    check_output("no_done_after_reset", 64'(done_valid), 64'd0);
                    @(negedge clock);
                end
                return;
            end
            @(negedge clock);
        end

        resp_valid = 1'b0;
        req_ready  = 1'b1;
        check_output("done_valid", 64'(done_valid), 64'd1);
        check_output("done_count", 64'(done_count), 64'(exp_count));
        check_output("done_error", 64'(done_error), 64'(exp_err));
        check_output("done_job_ready", 64'(job_ready), 64'd0);
        check_output("done_encoding", 64'(encoding), 64'(enc));
        @(negedge clock);
        check_output("after_done_job_ready", 64'(job_ready), 64'd1);
        check_output("after_done_valid", 64'(done_valid), 64'd0);
        check_output("held_done_count", 64'(done_count), 64'(exp_count));
        check_output("held_done_error", 64'(done_error), 64'(exp_err));
        check_output("held_encoding", 64'(encoding), 64'(enc));
    endtask

    task automatic clear_plan(input bit tail);
        resp_plan.delete();
        ready_plan.delete();
        tail_ready = tail;
    endtask

    task automatic random_plan(input int len);
        clear_plan(1'b1);
        for (int i = 0; i < len; i++) begin
            resp_plan.push_back(1'($urandom_range(0, 1)));
            ready_plan.push_back($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        job_valid    = 1'b0;
        job_encoding = 1'b0;
        job_head     = 32'd0;
        job_length   = 32'd0;
        job_csr      = '0;
        job_csr_mask = 4'd0;
        req_ready    = 1'b1;
        resp_valid   = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_reset_values();
        reset = 1'b0;
        @(negedge clock);

        // Encode job: 523 bytes, then Top ready again.
        clear_plan(1'b1);
        for (int i = 0; i < 523; i++) begin
            resp_plan.push_back(1'b1);
            ready_plan.push_back(1'b0);
        end
        apply_stimulus(1'b1, 32'd0, 32'd1000, {11'd0, 11'd1536, 11'd1024, 11'd0}, 4'b0111, 0, -1);

        // Decode job with a single CSR write and 1000 bytes.
        clear_plan(1'b1);
        for (int i = 0; i < 1000; i++) begin
            resp_plan.push_back(1'b1);
            ready_plan.push_back(1'b0);
        end
        apply_stimulus(1'b0, 32'h0000_1000, 32'd2000, {33'd0, 11'd256}, 4'b0001, 0, -1);

        // No CSRs, ISSUE stalled 5 cycles, ready high in the guard cycle.
        clear_plan(1'b1);
        resp_plan.push_back(1'b0);
        ready_plan.push_back(1'b1);
        for (int i = 0; i < 3; i++) begin
            resp_plan.push_back(1'b1);
            ready_plan.push_back(1'b0);
        end
        apply_stimulus(1'b1, 32'hDEAD_BEEF, 32'd77, 44'h0, 4'b0000, 5, -1);

        // Byte and ready in the same busy cycle.
        clear_plan(1'b1);
        resp_plan.push_back(1'b0);  ready_plan.push_back(1'b0);
        resp_plan.push_back(1'b1);  ready_plan.push_back(1'b0);
        resp_plan.push_back(1'b1);  ready_plan.push_back(1'b1);
        apply_stimulus(1'b0, 32'h0000_0040, 32'd16, 44'h0, 4'b1000, 1, -1);

        // Top never returns ready: watchdog fires, last-cycle byte still counted.
        clear_plan(1'b0);
        for (int i = 0; i <= TIMEOUT; i++) begin
            resp_plan.push_back((i < 10) || (i == TIMEOUT));
            ready_plan.push_back(1'b0);
        end
        apply_stimulus(1'b1, 32'h0000_0100, 32'd500, 44'h0, 4'b0000, 0, -1);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            random_plan($urandom_range(0, 40));
            apply_stimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                           44'({$urandom, $urandom}), 4'($urandom),
                           $urandom_range(0, 4), -1);
        end

        // Reset during BUSY, then a normal job.
        random_plan(30);
        for (int i = 0; i < 30; i++) ready_plan[i] = 1'b0;
        apply_stimulus(1'b1, 32'h1234_5678, 32'd99, 44'({$urandom, $urandom}), 4'b0101, 0, 10);
        random_plan($urandom_range(5, 20));
        apply_stimulus(1'b1, $urandom, $urandom, 44'({$urandom, $urandom}), 4'b1111, 2, -1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
